// File: rtl/layer_switch_gen.sv
// Layer switch-enable generator: issues per-channel one-cycle switch pulses on
// trigger events, repeated a configured number of times with a holdoff between fires.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | waiting for io_start; config captured on an accepted start
//  WAIT_TRIG | watching masked trigger source for any enabled channel
//  FIRE      | one cycle with io_switchEnLogic driving the captured trigger
//  HOLD      | holdoff countdown; triggers arriving here are dropped
//  END       | one-cycle io_layerEnd pulse, fire count cleared
module layer_switch_gen (
  input  logic        io_clk,
  input  logic        io_rst_n,
  input  logic        io_start,
  input  logic        io_abort,
  input  logic [7:0]  io_layerCfg,
  input  logic [15:0] io_layerCnt,
  input  logic        io_BaseLayer,
  input  logic        io_workingMode,
  input  logic [7:0]  io_fbCatch,
  input  logic [7:0]  io_delayEnd,
  input  logic [7:0]  io_holdoff,
  output logic [7:0]  io_switchEnLogic,
  output logic        io_layerLast,
  output logic        io_layerEnd,
  output logic        io_busy,
  output logic [15:0] io_fireCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_FIRE,
    S_HOLD,
    S_END
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cfg;
  logic [15:0] r_cnt;
  logic        r_base;
  logic        r_mode;
  logic [7:0]  r_holdoff;
  logic [7:0]  r_hold_cnt;
  logic [7:0]  r_sw;
  logic        r_layer_end;
  logic [15:0] r_fire_cnt;

  logic [7:0]  w_trig;
  logic        w_last;

  assign w_trig = r_cfg & (r_mode ? io_delayEnd : io_fbCatch);

  // cnt-1 is only formed when cnt is nonzero, so cnt = 0 never aliases to 0xFFFF.
  always_comb begin
    w_last = 1'b1;
    if (r_cnt != 16'd0) begin
      if (r_base)
        w_last = (r_fire_cnt == (r_cnt - 16'd1));
      else
        w_last = (r_fire_cnt == r_cnt);
    end
  end

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      r_state     <= S_IDLE;
      r_cfg       <= '0;
      r_cnt       <= '0;
      r_base      <= 1'b0;
      r_mode      <= 1'b0;
      r_holdoff   <= '0;
      r_hold_cnt  <= '0;
      r_sw        <= '0;
      r_layer_end <= 1'b0;
      r_fire_cnt  <= '0;
    end else begin
      r_sw        <= '0;
      r_layer_end <= 1'b0;
      if (io_abort) begin
        r_state    <= S_IDLE;
        r_fire_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (io_start) begin
              r_cfg      <= io_layerCfg;
              r_cnt      <= io_layerCnt;
              r_base     <= io_BaseLayer;
              r_mode     <= io_workingMode;
              r_holdoff  <= io_holdoff;
              r_fire_cnt <= '0;
              r_state    <= S_WAIT_TRIG;
            end
          end
          S_WAIT_TRIG: begin
            if (r_cfg == 8'd0) begin
              r_layer_end <= 1'b1;
              r_state     <= S_END;
            end else if (w_trig != 8'd0) begin
              r_sw    <= w_trig;
              r_state <= S_FIRE;
            end
          end
          S_FIRE: begin
            if (w_last) begin
              r_layer_end <= 1'b1;
              r_state     <= S_END;
            end else begin
              r_fire_cnt <= r_fire_cnt + 16'd1;
              r_hold_cnt <= r_holdoff;
              r_state    <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (r_hold_cnt == 8'd0)
              r_state <= S_WAIT_TRIG;
            else
              r_hold_cnt <= r_hold_cnt - 8'd1;
          end
          S_END: begin
            r_fire_cnt <= '0;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign io_switchEnLogic = r_sw;
  assign io_layerLast     = w_last;
  assign io_layerEnd      = r_layer_end;
  assign io_busy          = (r_state != S_IDLE);
  assign io_fireCount     = r_fire_cnt;

endmodule

// File: tb/tb_layer_switch_gen.sv
// Directed bench for layer_switch_gen: per-cycle vector table plus hand-written
// sequences for start-while-busy and asynchronous reset mid-fire.
module tb_layer_switch_gen;

  logic        io_clk;
  logic        io_rst_n;
  logic        io_start;
  logic        io_abort;
  logic [7:0]  io_layerCfg;
  logic [15:0] io_layerCnt;
  logic        io_BaseLayer;
  logic        io_workingMode;
  logic [7:0]  io_fbCatch;
  logic [7:0]  io_delayEnd;
  logic [7:0]  io_holdoff;
  logic [7:0]  io_switchEnLogic;
  logic        io_layerLast;
  logic        io_layerEnd;
  logic        io_busy;
  logic [15:0] io_fireCount;

  int n_vec = 0;
  int n_err = 0;

  layer_switch_gen dut (
    .io_clk          (io_clk),
    .io_rst_n        (io_rst_n),
    .io_start        (io_start),
    .io_abort        (io_abort),
    .io_layerCfg     (io_layerCfg),
    .io_layerCnt     (io_layerCnt),
    .io_BaseLayer    (io_BaseLayer),
    .io_workingMode  (io_workingMode),
    .io_fbCatch      (io_fbCatch),
    .io_delayEnd     (io_delayEnd),
    .io_holdoff      (io_holdoff),
    .io_switchEnLogic(io_switchEnLogic),
    .io_layerLast    (io_layerLast),
    .io_layerEnd     (io_layerEnd),
    .io_busy         (io_busy),
    .io_fireCount    (io_fireCount)
  );

  initial begin
    io_clk = 1'b0;
    forever #5 io_clk = ~io_clk;
  end

  typedef struct {
    logic        start;
    logic        abort;
    logic [7:0]  cfg;
    logic [15:0] cnt;
    logic        base;
    logic        mode;
    logic [7:0]  fb;
    logic [7:0]  de;
    logic [7:0]  hold;
    logic [7:0]  e_sw;
    logic        e_last;
    logic        e_end;
    logic        e_busy;
    logic [15:0] e_fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic start, logic abort, logic [7:0] cfg, logic [15:0] cnt,
                              logic base, logic mode, logic [7:0] fb, logic [7:0] de,
                              logic [7:0] hold, logic [7:0] e_sw, logic e_last,
                              logic e_end, logic e_busy, logic [15:0] e_fc);
    vec_t v;
    v.start = start; v.abort = abort; v.cfg = cfg; v.cnt = cnt; v.base = base;
    v.mode = mode; v.fb = fb; v.de = de; v.hold = hold; v.e_sw = e_sw;
    v.e_last = e_last; v.e_end = e_end; v.e_busy = e_busy; v.e_fc = e_fc;
    return v;
  endfunction

  task automatic drive(logic start, logic abort, logic [7:0] cfg, logic [15:0] cnt,
                       logic base, logic mode, logic [7:0] fb, logic [7:0] de,
                       logic [7:0] hold);
    io_start = start; io_abort = abort; io_layerCfg = cfg; io_layerCnt = cnt;
    io_BaseLayer = base; io_workingMode = mode; io_fbCatch = fb; io_delayEnd = de;
    io_holdoff = hold;
  endtask

  task automatic step();
    @(posedge io_clk);
    #1;
  endtask

  task automatic check(string nm, logic [7:0] sw, logic last, logic e_end, logic busy,
                       logic [15:0] fc);
    n_vec++;
    if (io_switchEnLogic !== sw || io_layerLast !== last || io_layerEnd !== e_end ||
        io_busy !== busy || io_fireCount !== fc) begin
      n_err++;
      $display("FAIL %s: got sw=%h last=%b end=%b busy=%b fc=%0d, want sw=%h last=%b end=%b busy=%b fc=%0d",
               nm, io_switchEnLogic, io_layerLast, io_layerEnd, io_busy, io_fireCount,
               sw, last, e_end, busy, fc);
    end
  endtask

  initial begin
    bit seen;

    // base=1, cnt=3, holdoff=2, fbCatch held at 0x07: three 0x05 fires, 5 cycles apart
    tbl.push_back(mk(1,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,0,0,1,16'd0));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h05,0,0,1,16'd0));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,0,0,1,16'd1));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,0,0,1,16'd1));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,0,0,1,16'd1));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,0,0,1,16'd1));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h05,0,0,1,16'd1));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,1,0,1,16'd2));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,1,0,1,16'd2));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,1,0,1,16'd2));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,1,0,1,16'd2));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h05,1,0,1,16'd2));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,1,1,1,16'd2));
    tbl.push_back(mk(1,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,0,0,0,16'd0));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,0,0,0,16'd0));
    // base=0, cnt=1, mode=1, holdoff=0: fbCatch ignored, two fires on delayEnd
    tbl.push_back(mk(1,0,8'h01,16'd1,0,1,8'hFF,8'h00,8'd0, 8'h00,0,0,1,16'd0));
    tbl.push_back(mk(0,0,8'h01,16'd1,0,1,8'hFF,8'h00,8'd0, 8'h00,0,0,1,16'd0));
    tbl.push_back(mk(0,0,8'h01,16'd1,0,1,8'h00,8'h00,8'd0, 8'h00,0,0,1,16'd0));
    tbl.push_back(mk(0,0,8'h01,16'd1,0,1,8'hFF,8'h01,8'd0, 8'h01,0,0,1,16'd0));
    tbl.push_back(mk(0,0,8'h01,16'd1,0,1,8'h00,8'h01,8'd0, 8'h00,1,0,1,16'd1));
    tbl.push_back(mk(0,0,8'h01,16'd1,0,1,8'h00,8'h01,8'd0, 8'h00,1,0,1,16'd1));
    tbl.push_back(mk(0,0,8'h01,16'd1,0,1,8'h00,8'h01,8'd0, 8'h01,1,0,1,16'd1));
    tbl.push_back(mk(0,0,8'h01,16'd1,0,1,8'h00,8'h01,8'd0, 8'h00,1,1,1,16'd1));
    tbl.push_back(mk(0,0,8'h01,16'd1,0,1,8'h00,8'h00,8'd0, 8'h00,0,0,0,16'd0));
    // cnt=0 with base=1: exactly one fire, layerLast high throughout
    tbl.push_back(mk(1,0,8'h05,16'd0,1,0,8'h07,8'h00,8'd2, 8'h00,1,0,1,16'd0));
    tbl.push_back(mk(0,0,8'h05,16'd0,1,0,8'h07,8'h00,8'd2, 8'h05,1,0,1,16'd0));
    tbl.push_back(mk(0,0,8'h05,16'd0,1,0,8'h07,8'h00,8'd2, 8'h00,1,1,1,16'd0));
    tbl.push_back(mk(0,0,8'h05,16'd0,1,0,8'h07,8'h00,8'd2, 8'h00,1,0,0,16'd0));
    // cfg=0: straight to END with no fire
    tbl.push_back(mk(1,0,8'h00,16'd3,1,0,8'hFF,8'hFF,8'd2, 8'h00,0,0,1,16'd0));
    tbl.push_back(mk(0,0,8'h00,16'd3,1,0,8'hFF,8'hFF,8'd2, 8'h00,0,1,1,16'd0));
    tbl.push_back(mk(0,0,8'h00,16'd3,1,0,8'hFF,8'hFF,8'd2, 8'h00,0,0,0,16'd0));
    // abort in HOLD after one fire, then abort together with start
    tbl.push_back(mk(1,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,0,0,1,16'd0));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h05,0,0,1,16'd0));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,0,0,1,16'd1));
    tbl.push_back(mk(0,1,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,0,0,0,16'd0));
    tbl.push_back(mk(1,1,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,0,0,0,16'd0));
    tbl.push_back(mk(0,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2, 8'h00,0,0,0,16'd0));

    io_rst_n = 1'b0;
    drive(0,0,8'h00,16'd0,0,0,8'h00,8'h00,8'd0);
    #3;
    check("reset_values", 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
    repeat (2) @(posedge io_clk);
    #1 io_rst_n = 1'b1;
    step();
    check("idle_after_reset", 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].abort, tbl[i].cfg, tbl[i].cnt, tbl[i].base,
            tbl[i].mode, tbl[i].fb, tbl[i].de, tbl[i].hold);
      step();
      check($sformatf("vec%0d", i), tbl[i].e_sw, tbl[i].e_last, tbl[i].e_end,
            tbl[i].e_busy, tbl[i].e_fc);
    end

    // Second start while busy must not recapture config (mode/cfg/cnt/base).
    drive(1,0,8'h01,16'd1,1,0,8'h00,8'h00,8'd0);
    step();
    check("busy_start_accept", 8'h00, 1'b1, 1'b0, 1'b1, 16'd0);
    drive(1,0,8'hFF,16'd5,0,1,8'h00,8'hFF,8'd7);
    step();
    check("busy_start_ignored", 8'h00, 1'b1, 1'b0, 1'b1, 16'd0);
    drive(0,0,8'hFF,16'd5,0,1,8'hFF,8'h00,8'd7);
    step();
    check("busy_fire_old_cfg", 8'h01, 1'b1, 1'b0, 1'b1, 16'd0);
    step();
    check("busy_layer_end", 8'h00, 1'b1, 1'b1, 1'b1, 16'd0);
    step();
    check("busy_back_idle", 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);

    // Asynchronous reset while a pulse is on the output.
    drive(1,0,8'h05,16'd3,1,0,8'h07,8'h00,8'd2);
    step();
    io_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (io_switchEnLogic != 8'h00) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL rst_wait_fire: got no pulse in 20 cycles, want a 0x05 pulse");
    end
    check("rst_pre_pulse", 8'h05, 1'b0, 1'b0, 1'b1, 16'd0);
    #1 io_rst_n = 1'b0;
    #1;
    check("rst_async_clear", 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
    #1 io_rst_n = 1'b1;
    step();
    check("rst_release_idle", 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
    step();
    check("rst_stays_idle", 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
